// File: rtl/alu_exec_unit.sv
// alu_exec_unit: executes one ALUControl operation per input handshake.
// Logic and arithmetic ops finish in one cycle. Shifts step one bit per cycle.
// The registered result and its zero flag are returned on an output handshake.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer holds valid and payload
// stable until that edge. ready may depend combinationally on the consumer's
// inputs: in_ready looks at out_ready so that DONE can hand off and accept in
// the same cycle. in_valid never feeds back into in_ready.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [1:0]       state_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_right_q, dir_right_d;

  logic             accept;
  logic             is_shift;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] op_res;
  logic             slt_bit;

  // Handshake signals. in_ready is forced low while reset is asserted.
  always_comb begin
    in_ready  = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    accept    = in_valid & in_ready;
    out_valid = (state_q == DONE);
    zero      = (result_q == '0);
    result    = result_q;
    state_o   = state_q;
  end

  // Single-cycle result for every op. A shift here is only taken when the amount is 0.
  always_comb begin
    shamt    = src_b[SHW-1:0];
    is_shift = (alu_control == OP_SLL) | (alu_control == OP_SRL);
    // True signed compare. The sign of (a-b) would be wrong when the subtraction overflows.
    slt_bit  = ($signed(src_a) < $signed(src_b));
    op_res   = '0;
    case (alu_control)
      OP_ADD:  op_res = src_a + src_b;
      OP_SLL:  op_res = src_a;
      OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SUB:  op_res = src_a - src_b;
      OP_XOR:  op_res = src_a ^ src_b;
      OP_SRL:  op_res = src_a;
      OP_OR:   op_res = src_a | src_b;
      OP_AND:  op_res = src_a & src_b;
      default: op_res = '0;
    endcase
  end

  // Next state: capture at accept, step shifts one bit per cycle, release on out_ready.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    dir_right_d = dir_right_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            result_d    = src_a;
            cnt_d       = shamt;
            dir_right_d = (alu_control == OP_SRL);
            state_d     = SHIFT;
          end else begin
            result_d = op_res;
            state_d  = DONE;
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        result_d = dir_right_q ? (result_q >> 1) : (result_q << 1);
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset drops any operation that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      dir_right_q <= dir_right_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and random operations are checked against a reference model.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_control;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic [1:0]   state_o;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .state_o     (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [W:0] exp_q[$];   // {zero, result}
  int         lat_q[$];
  int         acc_q[$];
  bit         head_seen = 1'b0;
  int         n_checks  = 0;
  int         n_fail    = 0;
  bit         bp_en     = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: each op written from its arithmetic meaning.
  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sh;
    sh = int'(b % W);
    case (op)
      3'd0: return a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 1 : 0;
      3'd3: return a - b;
      3'd4: return a ^ b;
      3'd5: return a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] b);
    int sh;
    sh = int'(b % W);
    if ((op == 3'd1 || op == 3'd5) && sh != 0) return sh + 1;
    return 1;
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge. Returns just after the edge that accepted the op.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int acc_cyc);
    int waited;
    bit done;
    logic [W-1:0] r;
    waited = 0;
    done = 1'b0;
    acc_cyc = -1;
    in_valid = 1'b1;
    alu_control = op;
    src_a = a;
    src_b = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        r = ref_op(op, a, b);
        exp_q.push_back({(r == '0), r});
        lat_q.push_back(ref_lat(op, b));
        acc_q.push_back(cyc);
        acc_cyc = cyc;
        done = 1'b1;
      end else if (++waited > 200) begin
        check("accept_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    // Scramble the inputs so that a unit which fails to capture at accept is caught.
    alu_control = 3'($urandom);
    src_a = $urandom;
    src_b = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        if (!head_seen) begin
          head_seen = 1'b1;
          check("latency", 64'(cyc - acc_q[0]), 64'(lat_q[0]));
        end
        check("result", 64'(result), 64'(exp_q[0][W-1:0]));
        check("zero", 64'(zero), 64'(exp_q[0][W]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          void'(acc_q.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  // Random backpressure while the random phase is running.
  always @(posedge clk) begin
    #1;
    if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- stimulus ----------------
  initial begin
    int a1, a2, lo_cnt, bad;
    logic [2:0] op;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    alu_control = 3'd0;
    src_a = '0;
    src_b = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_state", 64'(state_o), 64'd0);

    // ADD with signed overflow wraps.
    issue(3'd0, 32'h7FFF_FFFF, 32'h1, a1);
    drain();

    // SUB to zero, with the output held under backpressure.
    out_ready = 1'b0;
    issue(3'd3, 32'h1234_5678, 32'h1234_5678, a1);
    repeat (3) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", 64'(result), 64'd0);
      check("hold_zero", 64'(zero), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Longest shift: in_ready stays low for every SHIFT cycle.
    issue(3'd1, 32'h1, 32'd31, a1);
    lo_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
      lo_cnt++;
    end
    check("sll31_busy_cycles", 64'(lo_cnt), 64'd31);
    drain();
    issue(3'd5, 32'h8000_0000, 32'h21, a1);
    drain();

    // SLT in both directions, then the bitwise ops.
    issue(3'd2, 32'hFFFF_FFFF, 32'h1, a1);
    issue(3'd2, 32'h1, 32'hFFFF_FFFF, a1);
    issue(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, a1);
    issue(3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, a1);
    issue(3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, a1);
    drain();

    // Back-to-back: the second op is accepted on the edge right after the first.
    issue(3'd0, 32'd5, 32'd7, a1);
    issue(3'd7, 32'hFF, 32'h0F, a2);
    check("back_to_back_gap", 64'(a2 - a1), 64'd1);
    drain();

    // Random ops with random backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) rb = ra;
      if ((op == 3'd1 || op == 3'd5) && $urandom_range(0, 1) == 1) rb = 32'($urandom_range(0, 7));
      issue(op, ra, rb, a1);
    end
    bp_en = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    // Reset in the middle of a shift drops the op.
    issue(3'd1, 32'hA5A5_0001, 32'd20, a1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_zero", 64'(zero), 64'd1);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    head_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", 64'(in_ready), 64'd1);
    check("postrst_state", 64'(state_o), 64'd0);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("postrst_no_stale", 64'(bad), 64'd0);

    // A normal op still works after the reset.
    @(posedge clk);
    #1;
    issue(3'd3, 32'd3, 32'd5, a1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
